text_console_ctrl: RTL

- Write-side controller for the 80x30 character text memory: owns write port A.
- Accepts ASCII bytes from a producer (UART/CPU) over a valid/ready handshake and tracks a cursor.
- Interprets a small set of control codes and sequences full-screen clears.
- Display scan-out on port B is untouched; the glyph ROM path is unchanged.

---
 rtl/text_pkg.sv | 27 ++
 rtl/text_addr_gen.sv | 18 +
 rtl/text_console_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// ==== text_pkg : shared geometry, ASCII codes and console state type ====
// ==== Revision 1.0 ======================================================
`default_nettype none

package text_pkg;

  localparam int TEXT_COLS   = 80;
  localparam int TEXT_ROWS   = 30;
  localparam int TEXT_CELLS  = 2400;
  localparam int TEXT_ADDR_W = 12;

  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_FF    = 8'h0C;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } console_state_t;

endpackage

`default_nettype wire

// File: rtl/text_addr_gen.sv
// ==== text_addr_gen : (col,row) -> cell address, row*80 by shift-add ===
// ==== Revision 1.0 ======================================================
`default_nettype none

module text_addr_gen
  import text_pkg::*;
(
  input  logic [6:0]             col,
  input  logic [4:0]             row,
  output logic [TEXT_ADDR_W-1:0] addr
);

  // row*80 = row*64 + row*16; largest result 29*80+79 = 2399 fits 12 bits
  assign addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};

endmodule

`default_nettype wire

// File: rtl/text_console_ctrl.sv
// ==== text_console_ctrl : text memory write port, cursor, control codes ==
// ==== Revision 1.0 ; option macro TEXT_CONSOLE_AUTOCLEAR_EN ==============
`default_nettype none

module text_console_ctrl
  import text_pkg::*;
#(
  parameter int         COLS      = TEXT_COLS,
  parameter int         ROWS      = TEXT_ROWS,
  parameter logic [7:0] FILL_CHAR = ASC_SPACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

  console_state_t state, state_n;
  logic [11:0]    cnt, cnt_n;
  logic           pend, pend_n;
  logic           we_n, ready_n, busy_n;
  logic [11:0]    addr_n;
  logic [7:0]     din_n;
  logic [6:0]     col_n;
  logic [4:0]     row_n;
  logic           do_clear, adv;
  logic [6:0]     ag_col;
  logic [11:0]    ag_addr;

  // Backspace writes the cell left of the cursor, everything else the cursor cell
  assign ag_col = (char_data == ASC_BS) ? cursor_col - 7'd1 : cursor_col;

  text_addr_gen u_addr_gen (
    .col  (ag_col),
    .row  (cursor_row),
    .addr (ag_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      char_ready <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      char_ready <= ready_n;
      busy       <= busy_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_din    <= din_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pend_n   = pend;
    we_n     = 1'b0;
    addr_n   = mem_addr;
    din_n    = mem_din;
    col_n    = cursor_col;
    row_n    = cursor_row;
    do_clear = 1'b0;
    adv      = 1'b0;

    unique case (state)
      IDLE: begin
        if (clear_req) begin
          do_clear = 1'b1;
        end else if (char_valid && char_ready) begin
          if (char_data >= ASC_SPACE && char_data <= ASC_TILDE) begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = ag_addr;
            din_n   = char_data;
            adv     = 1'b1;
          end else begin
            unique case (char_data)
              ASC_CR: col_n = '0;
              ASC_LF: begin
                col_n = '0;
                if (cursor_row == ROW_MAX) begin
                  row_n = '0;
`ifdef TEXT_CONSOLE_AUTOCLEAR_EN
                  do_clear = 1'b1;
`endif
                end else begin
                  row_n = cursor_row + 5'd1;
                end
              end
              ASC_BS: begin
                if (cursor_col != '0) begin
                  col_n   = cursor_col - 7'd1;
                  state_n = WRITE;
                  we_n    = 1'b1;
                  addr_n  = ag_addr;
                  din_n   = FILL_CHAR;
                end
              end
              ASC_FF:  do_clear = 1'b1;
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        if (pend) begin
          do_clear = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR: begin
        if (cnt == LAST_CELL) begin
          state_n = IDLE;
          col_n   = '0;
          row_n   = '0;
        end else begin
          we_n   = 1'b1;
          cnt_n  = cnt + 12'd1;
          addr_n = cnt + 12'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (adv) begin
      if (cursor_col == COL_MAX) begin
        col_n = '0;
        if (cursor_row == ROW_MAX) begin
          row_n = '0;
`ifdef TEXT_CONSOLE_AUTOCLEAR_EN
          pend_n = 1'b1;
`endif
        end else begin
          row_n = cursor_row + 5'd1;
        end
      end else begin
        col_n = cursor_col + 7'd1;
      end
    end

    // Sweep starts at cell 0 in the same edge that enters CLEAR
    if (do_clear) begin
      state_n = CLEAR;
      we_n    = 1'b1;
      addr_n  = '0;
      din_n   = FILL_CHAR;
      cnt_n   = '0;
      pend_n  = 1'b0;
    end

    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

endmodule

`default_nettype wire
